// File: rtl/aq_gemac_mdio_resp_if.sv
// Pad-side MDIO signals and register-file strobe bus for the MDIO responder.
// Strobes: REG_RE/REG_WE are one-CLK pulses with no back-pressure; REG_RDATA must be valid the cycle after REG_RE.
interface aq_gemac_mdio_resp_if;
  logic        MDC;
  logic        MDIO_IN;
  logic        MDIO_OUT;
  logic        MDIO_OUT_ENABLE;
  logic [4:0]  REG_ADDR;
  logic        REG_RE;
  logic [15:0] REG_RDATA;
  logic        REG_WE;
  logic [15:0] REG_WDATA;
  logic        BUSY;
  logic        FRAME_ERR;
  logic [2:0]  DBG_STATE;

  modport slave (
    input  MDC, MDIO_IN, REG_RDATA,
    output MDIO_OUT, MDIO_OUT_ENABLE, REG_ADDR, REG_RE, REG_WE, REG_WDATA,
           BUSY, FRAME_ERR, DBG_STATE
  );

  modport master (
    output MDC, MDIO_IN, REG_RDATA,
    input  MDIO_OUT, MDIO_OUT_ENABLE, REG_ADDR, REG_RE, REG_WE, REG_WDATA,
           BUSY, FRAME_ERR, DBG_STATE
  );
endinterface

// File: rtl/aq_gemac_mdio_resp.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on CLK, decodes frames and
// turns them into single-cycle register read/write strobes.
module aq_gemac_mdio_resp #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_LEN  = 32
) (
    input logic                   CLK,
    input logic                   RST,
    aq_gemac_mdio_resp_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ST    = 3'd1,
        OP    = 3'd2,
        PHYAD = 3'd3,
        REGAD = 3'd4,
        TA    = 3'd5,
        DATA  = 3'd6,
        SKIP  = 3'd7
    } state_t;

    localparam logic [6:0] PRE_LEN_C = 7'(PRE_LEN);

    state_t      state_q, state_d;
    logic        mdc_s1_q, mdc_s2_q, mdc_prev_q;
    logic        mdio_s1_q, mdio_s2_q;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        is_read_q, is_read_d;
    logic        op_hi_q, op_hi_d;
    logic [4:0]  phyad_q, phyad_d;
    logic [4:0]  regad_q, regad_d;
    logic [15:0] shreg_q, shreg_d;
    logic        mdio_out_q, mdio_out_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic        reg_re_q, reg_re_d;
    logic        load_q, load_d;
    logic        reg_we_q, reg_we_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        frame_err_q, frame_err_d;

    logic rise;
    logic bit_in;

    assign rise   = mdc_s2_q & ~mdc_prev_q;
    assign bit_in = mdio_s2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mdc_s1_q   <= 1'b0;
            mdc_s2_q   <= 1'b0;
            mdc_prev_q <= 1'b0;
            mdio_s1_q  <= 1'b0;
            mdio_s2_q  <= 1'b0;
        end else begin
            mdc_s1_q   <= bus.MDC;
            mdc_s2_q   <= mdc_s1_q;
            mdc_prev_q <= mdc_s2_q;
            mdio_s1_q  <= bus.MDIO_IN;
            mdio_s2_q  <= mdio_s1_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            op_hi_q     <= 1'b0;
            phyad_q     <= '0;
            regad_q     <= '0;
            shreg_q     <= '0;
            mdio_out_q  <= 1'b0;
            mdio_oe_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_re_q    <= 1'b0;
            load_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            is_read_q   <= is_read_d;
            op_hi_q     <= op_hi_d;
            phyad_q     <= phyad_d;
            regad_q     <= regad_d;
            shreg_q     <= shreg_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oe_q   <= mdio_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_re_q    <= reg_re_d;
            load_q      <= load_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        is_read_d   = is_read_q;
        op_hi_d     = op_hi_q;
        phyad_d     = phyad_q;
        regad_d     = regad_q;
        shreg_d     = shreg_q;
        mdio_out_d  = mdio_out_q;
        mdio_oe_d   = mdio_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_re_d    = 1'b0;
        reg_we_d    = 1'b0;
        frame_err_d = 1'b0;
        load_d      = reg_re_q;

        // Read data arrives one CLK after the strobe, long before the next MDC rise.
        if (load_q) begin
            shreg_d = bus.REG_RDATA;
        end

        if (rise) begin
            case (state_q)
                IDLE: begin
                    if (bit_in) begin
                        if (pre_cnt_q != 6'h3f) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if ({1'b0, pre_cnt_q} >= PRE_LEN_C) begin
                        state_d = ST;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                ST: begin
                    if (bit_in) begin
                        state_d   = OP;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                OP: begin
                    if (bit_cnt_q == 5'd0) begin
                        op_hi_d   = bit_in;
                        bit_cnt_d = 5'd1;
                    end else if (op_hi_q != bit_in) begin
                        is_read_d = op_hi_q;
                        state_d   = PHYAD;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                PHYAD: begin
                    phyad_d = {phyad_q[3:0], bit_in};
                    if (bit_cnt_q == 5'd4) begin
                        state_d   = REGAD;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                REGAD: begin
                    regad_d = {regad_q[3:0], bit_in};
                    if (bit_cnt_q == 5'd4) begin
                        reg_addr_d = {regad_q[3:0], bit_in};
                        bit_cnt_d  = '0;
                        if (phyad_q == PHY_ADDR) begin
                            state_d  = TA;
                            reg_re_d = is_read_q;
                        end else begin
                            state_d = SKIP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                TA: begin
                    // Reads drive a single turnaround zero; writes just let both TA bits pass.
                    if (is_read_q) begin
                        mdio_oe_d  = 1'b1;
                        mdio_out_d = 1'b0;
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                    end else if (bit_cnt_q == 5'd1) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = 5'd1;
                    end
                end
                DATA: begin
                    if (is_read_q) begin
                        if (bit_cnt_q == 5'd16) begin
                            mdio_oe_d  = 1'b0;
                            mdio_out_d = 1'b0;
                            state_d    = IDLE;
                        end else begin
                            mdio_out_d = shreg_q[15];
                            shreg_d    = {shreg_q[14:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        shreg_d = {shreg_q[14:0], bit_in};
                        if (bit_cnt_q == 5'd15) begin
                            reg_we_d    = 1'b1;
                            reg_wdata_d = {shreg_q[14:0], bit_in};
                            state_d     = IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                SKIP: begin
                    if (bit_cnt_q == 5'd17) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Preamble only accumulates while idle, so every frame needs a fresh one.
        if (state_d != IDLE) begin
            pre_cnt_d = '0;
        end
    end

    assign bus.MDIO_OUT        = mdio_out_q;
    assign bus.MDIO_OUT_ENABLE = mdio_oe_q;
    assign bus.REG_ADDR        = reg_addr_q;
    assign bus.REG_RE          = reg_re_q;
    assign bus.REG_WE          = reg_we_q;
    assign bus.REG_WDATA       = reg_wdata_q;
    assign bus.BUSY            = (state_q != IDLE);
    assign bus.FRAME_ERR       = frame_err_q;
    assign bus.DBG_STATE       = state_q;

endmodule
